// File: rtl/comma_align.sv
// Comma word aligner: searches a two-group window of the deserialized stream for K28.x
// commas, locks a bit offset and forwards aligned 10-bit groups to the 8b10b decoder.
module comma_align #(
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] raw_data_in,
  output logic [9:0] encode_data_out,
  output logic       comma_det,
  output logic       sync,
  output logic [3:0] align_offset
);

  localparam int MAX_CNT = (LOCK_CNT > LOSS_CNT) ? LOCK_CNT : LOSS_CNT;
  localparam int CW      = $clog2(MAX_CNT) + 1;

  localparam logic [1:0] HUNT   = 2'd0;
  localparam logic [1:0] VERIFY = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  logic [9:0]    r1;
  logic [9:0]    r2;
  logic [18:0]   win;
  logic [9:0]    cand [10];
  logic [9:0]    match;
  logic          any_comma;
  logic [3:0]    first_off;
  logic [9:0]    aligned;
  logic          aligned_comma;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [CW-1:0] miss;
  logic [CW-1:0] miss_nxt;
  logic [3:0]    off_nxt;

  // Only the seven leading bits (abcdeif) identify K28.x, in either running disparity.
  function automatic logic is_comma(input logic [6:0] head);
    return (head == 7'b0011111) || (head == 7'b1100000);
  endfunction

  // The newest group's last bit never starts a candidate, so it is left out of the window.
  assign win = {r2, r1[9:1]};

  always_comb begin
    for (int k = 0; k < 10; k++) begin
      cand[k]  = win[18-k -: 10];
      match[k] = is_comma(cand[k][9:3]);
    end
  end

  // Lowest matching offset wins when a window holds several commas.
  always_comb begin
    any_comma = |match;
    first_off = 4'd0;
    for (int k = 9; k >= 0; k--) begin
      if (match[k]) begin
        first_off = 4'(k);
      end
    end
  end

  always_comb begin
    aligned       = 10'd0;
    aligned_comma = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (align_offset == 4'(k)) begin
        aligned       = cand[k];
        aligned_comma = match[k];
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    miss_nxt  = miss;
    off_nxt   = align_offset;
    case (state)
      HUNT: begin
        if (any_comma) begin
          off_nxt = first_off;
          if (LOCK_CNT == 1) begin
            state_nxt = LOCKED;
            cnt_nxt   = '0;
            miss_nxt  = '0;
          end else begin
            state_nxt = VERIFY;
            cnt_nxt   = CW'(1);
          end
        end
      end
      VERIFY: begin
        if (aligned_comma) begin
          if (cnt + CW'(1) == CW'(LOCK_CNT)) begin
            state_nxt = LOCKED;
            cnt_nxt   = '0;
            miss_nxt  = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end else if (any_comma) begin
          off_nxt = first_off;
          cnt_nxt = CW'(1);
        end
      end
      LOCKED: begin
        // The offset is frozen here; only a run of misplaced commas releases the lock.
        if (aligned_comma) begin
          miss_nxt = '0;
        end else if (any_comma) begin
          if (miss + CW'(1) == CW'(LOSS_CNT)) begin
            state_nxt = HUNT;
            cnt_nxt   = '0;
            miss_nxt  = '0;
          end else begin
            miss_nxt = miss + CW'(1);
          end
        end
      end
      default: begin
        state_nxt = HUNT;
        cnt_nxt   = '0;
        miss_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r1              <= 10'd0;
      r2              <= 10'd0;
      encode_data_out <= 10'd0;
      comma_det       <= 1'b0;
      state           <= HUNT;
      cnt             <= '0;
      miss            <= '0;
      align_offset    <= 4'd0;
      sync            <= 1'b0;
    end else begin
      r1              <= raw_data_in;
      r2              <= r1;
      encode_data_out <= aligned;
      comma_det       <= aligned_comma;
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      miss            <= miss_nxt;
      align_offset    <= off_nxt;
      sync            <= (state_nxt == LOCKED);
    end
  end

endmodule

// File: tb/tb_comma_align.sv
// Directed bench for comma_align: lock at offsets 0/3/5, both comma disparities,
// loss of sync, miss-counter clearing and mid-lock reset.
module tb_comma_align;

  logic       clk;
  logic       rst;
  logic [9:0] raw_data_in;
  logic [9:0] encode_data_out;
  logic       comma_det;
  logic       sync;
  logic [3:0] align_offset;

  int total = 0;
  int bad   = 0;

  comma_align #(.LOCK_CNT(3), .LOSS_CNT(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .raw_data_in     (raw_data_in),
    .encode_data_out (encode_data_out),
    .comma_det       (comma_det),
    .sync            (sync),
    .align_offset    (align_offset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] pat4(input int n);
    return (n % 4 == 0) ? 10'h0FA : 10'h2AA;
  endfunction

  function automatic logic [9:0] seq3(input int n);
    if (n % 8 == 0) return 10'h0FA;
    if (n % 8 == 4) return 10'h305;
    return 10'h2AA;
  endfunction

  // Group n of the pat4 bitstream delayed by sh bits (earlier bits continue the pattern).
  function automatic logic [9:0] shift_word(input int n, input int sh);
    logic [9:0] r;
    logic [9:0] wd;
    int p;
    r = '0;
    for (int b = 0; b < 10; b++) begin
      p = 10 * n + b - sh + 400;
      wd = pat4(p / 10);
      r[9-b] = wd[9 - (p % 10)];
    end
    return r;
  endfunction

  task automatic step(input logic [9:0] w);
    raw_data_in = w;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(10'h3FF);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(10'h3FF);
    step(10'h0FA);
    if (encode_data_out !== 10'd0) begin bad++; $display("[TB] FAIL reset_out got=%h want=000", encode_data_out); end
    total++;
    if (comma_det !== 1'b0) begin bad++; $display("[TB] FAIL reset_cd got=%b want=0", comma_det); end
    total++;
    if (sync !== 1'b0) begin bad++; $display("[TB] FAIL reset_sync got=%b want=0", sync); end
    total++;
    if (align_offset !== 4'd0) begin bad++; $display("[TB] FAIL reset_off got=%0d want=0", align_offset); end
    total++;
    rst = 1'b0;
  endtask

  task automatic test_offset0();
    logic [9:0] eo;
    logic ecd;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(pat4(i));
      eo  = (i >= 2) ? pat4(i - 2) : 10'd0;
      ecd = (i >= 2) && ((i - 2) % 4 == 0);
      if (encode_data_out !== eo) begin bad++; $display("[TB] FAIL off0_out i=%0d got=%h want=%h", i, encode_data_out, eo); end
      total++;
      if (comma_det !== ecd) begin bad++; $display("[TB] FAIL off0_cd i=%0d got=%b want=%b", i, comma_det, ecd); end
      total++;
      if (sync !== (i >= 10)) begin bad++; $display("[TB] FAIL off0_sync i=%0d got=%b want=%b", i, sync, (i >= 10)); end
      total++;
      if (align_offset !== 4'd0) begin bad++; $display("[TB] FAIL off0_off i=%0d got=%0d want=0", i, align_offset); end
      total++;
    end
  endtask

  task automatic test_offset3();
    logic [3:0] eoff;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(shift_word(i, 3));
      eoff = (i >= 2) ? 4'd3 : 4'd0;
      if (i >= 3) begin
        if (encode_data_out !== pat4(i - 2)) begin bad++; $display("[TB] FAIL off3_out i=%0d got=%h want=%h", i, encode_data_out, pat4(i - 2)); end
        total++;
        if (comma_det !== ((i - 2) % 4 == 0)) begin bad++; $display("[TB] FAIL off3_cd i=%0d got=%b want=%b", i, comma_det, ((i - 2) % 4 == 0)); end
        total++;
      end
      if (sync !== (i >= 10)) begin bad++; $display("[TB] FAIL off3_sync i=%0d got=%b want=%b", i, sync, (i >= 10)); end
      total++;
      if (align_offset !== eoff) begin bad++; $display("[TB] FAIL off3_off i=%0d got=%0d want=%0d", i, align_offset, eoff); end
      total++;
    end
  endtask

  task automatic test_both_disparity();
    logic [9:0] eo;
    logic ecd;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(seq3(i));
      eo  = (i >= 2) ? seq3(i - 2) : 10'd0;
      ecd = (i >= 2) && ((i - 2) % 4 == 0);
      if (encode_data_out !== eo) begin bad++; $display("[TB] FAIL rd_out i=%0d got=%h want=%h", i, encode_data_out, eo); end
      total++;
      if (comma_det !== ecd) begin bad++; $display("[TB] FAIL rd_cd i=%0d got=%b want=%b", i, comma_det, ecd); end
      total++;
      if (sync !== (i >= 10)) begin bad++; $display("[TB] FAIL rd_sync i=%0d got=%b want=%b", i, sync, (i >= 10)); end
      total++;
    end
  endtask

  task automatic test_verify_restart();
    logic [3:0] eoff;
    do_reset();
    for (int i = 0; i < 28; i++) begin
      step((i < 8) ? pat4(i) : shift_word(i - 8, 5));
      eoff = (i >= 10) ? 4'd5 : 4'd0;
      if (align_offset !== eoff) begin bad++; $display("[TB] FAIL vr_off i=%0d got=%0d want=%0d", i, align_offset, eoff); end
      total++;
      if (sync !== (i >= 18)) begin bad++; $display("[TB] FAIL vr_sync i=%0d got=%b want=%b", i, sync, (i >= 18)); end
      total++;
      if (i >= 11) begin
        if (encode_data_out !== pat4(i - 10)) begin bad++; $display("[TB] FAIL vr_out i=%0d got=%h want=%h", i, encode_data_out, pat4(i - 10)); end
        total++;
        if (comma_det !== ((i - 10) % 4 == 0)) begin bad++; $display("[TB] FAIL vr_cd i=%0d got=%b want=%b", i, comma_det, ((i - 10) % 4 == 0)); end
        total++;
      end
    end
  endtask

  task automatic test_loss();
    logic esync;
    logic [3:0] eoff;
    do_reset();
    for (int i = 0; i < 32; i++) begin
      step((i < 12) ? pat4(i) : shift_word(i - 12, 7));
      esync = (i >= 10) && (i < 26);
      eoff  = (i >= 30) ? 4'd7 : 4'd0;
      if (sync !== esync) begin bad++; $display("[TB] FAIL loss_sync i=%0d got=%b want=%b", i, sync, esync); end
      total++;
      if (align_offset !== eoff) begin bad++; $display("[TB] FAIL loss_off i=%0d got=%0d want=%0d", i, align_offset, eoff); end
      total++;
      if (i >= 12) begin
        if (comma_det !== 1'b0) begin bad++; $display("[TB] FAIL loss_cd i=%0d got=%b want=0", i, comma_det); end
        total++;
      end
    end
  endtask

  task automatic test_miss_clear();
    logic [9:0] w;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      if (i < 12)       w = pat4(i);
      else if (i < 24)  w = shift_word(i - 12, 7);
      else if (i < 28)  w = pat4(i - 24);
      else              w = shift_word(i - 28, 7);
      step(w);
      if (sync !== (i >= 10)) begin bad++; $display("[TB] FAIL mc_sync i=%0d got=%b want=%b", i, sync, (i >= 10)); end
      total++;
      if (align_offset !== 4'd0) begin bad++; $display("[TB] FAIL mc_off i=%0d got=%0d want=0", i, align_offset); end
      total++;
      if (i == 26) begin
        if (encode_data_out !== 10'h0FA) begin bad++; $display("[TB] FAIL mc_out got=%h want=0fa", encode_data_out); end
        total++;
        if (comma_det !== 1'b1) begin bad++; $display("[TB] FAIL mc_cd got=%b want=1", comma_det); end
        total++;
      end
    end
  endtask

  task automatic test_reset_locked();
    do_reset();
    for (int i = 0; i < 12; i++) step(pat4(i));
    if (sync !== 1'b1) begin bad++; $display("[TB] FAIL rl_pre_sync got=%b want=1", sync); end
    total++;
    rst = 1'b1;
    step(pat4(12));
    rst = 1'b0;
    if (sync !== 1'b0) begin bad++; $display("[TB] FAIL rl_sync got=%b want=0", sync); end
    total++;
    if (encode_data_out !== 10'd0) begin bad++; $display("[TB] FAIL rl_out got=%h want=000", encode_data_out); end
    total++;
    if (align_offset !== 4'd0) begin bad++; $display("[TB] FAIL rl_off got=%0d want=0", align_offset); end
    total++;
    if (comma_det !== 1'b0) begin bad++; $display("[TB] FAIL rl_cd got=%b want=0", comma_det); end
    total++;
    for (int i = 0; i < 12; i++) begin
      step(pat4(i));
      if (sync !== (i >= 10)) begin bad++; $display("[TB] FAIL rl_relock i=%0d got=%b want=%b", i, sync, (i >= 10)); end
      total++;
      if (encode_data_out !== ((i >= 2) ? pat4(i - 2) : 10'd0)) begin
        bad++; $display("[TB] FAIL rl_out2 i=%0d got=%h want=%h", i, encode_data_out, ((i >= 2) ? pat4(i - 2) : 10'd0));
      end
      total++;
    end
  endtask

  initial begin
    rst = 1'b1;
    raw_data_in = 10'd0;
    test_reset();
    test_offset0();
    test_offset3();
    test_both_disparity();
    test_verify_restart();
    test_loss();
    test_miss_clear();
    test_reset_locked();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
